pkt_tx_buf: RTL and testbench

//  Per-channel ingress packet buffer feeding the SERDES TX scheduler (one instance per channel, 8 total).

---
 rtl/pkt_tx_buf.sv | 175 +++++++++++++++++
 tb/tb_pkt_tx_buf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_buf.sv
// Per-channel ingress packet buffer: stores packets in a circular RAM and queues one
// descriptor {3'b000,len,start} per good packet for the SERDES TX scheduler.
module pkt_tx_buf #(
  parameter int RAM_DEPTH   = 11,
  parameter int DESC_AW     = 4,
  parameter int MAX_LEN     = 94,
  parameter int GUARD_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          i_in_data,
  input  logic                 i_in_sof,
  input  logic                 i_in_eof,
  input  logic                 i_in_vld,
  output logic                 o_in_rdy,
  input  logic                 i_fifo_rden,
  output logic [23:0]          o_fifo_dout,
  output logic                 o_pkt_rdy,
  input  logic [RAM_DEPTH-1:0] i_ram_raddr,
  output logic [15:0]          o_ram_dout,
  output logic [15:0]          o_drop_cnt
);

  localparam int AW1        = RAM_DEPTH + 1;
  localparam int CW         = DESC_AW + 1;
  localparam int RAM_WORDS  = 1 << RAM_DEPTH;
  localparam int FIFO_WORDS = 1 << DESC_AW;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t               r_state;
  logic [RAM_DEPTH-1:0] r_wr_ptr;
  logic [RAM_DEPTH-1:0] r_start;
  logic [9:0]           r_wr_cnt;
  logic [AW1-1:0]       r_committed;
  logic [CW-1:0]        r_count;
  logic [DESC_AW-1:0]   r_fifo_wp;
  logic [DESC_AW-1:0]   r_fifo_rp;
  logic                 r_live;
  logic [23:0]          r_fifo_dout;
  logic                 r_pkt_rdy;
  logic [15:0]          r_ram_dout;
  logic [15:0]          r_drop_cnt;
  logic [15:0]          r_ram  [RAM_WORDS];
  logic [23:0]          r_desc [FIFO_WORDS];

  logic [AW1-1:0]       w_free;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_pop;
  logic [9:0]           w_pop_len;
  state_t               w_state_n;
  logic [RAM_DEPTH-1:0] w_wr_ptr_n;
  logic [RAM_DEPTH-1:0] w_start_n;
  logic [9:0]           w_wr_cnt_n;
  logic                 w_we;
  logic [RAM_DEPTH-1:0] w_waddr;
  logic                 w_push;
  logic [9:0]           w_push_len;
  logic                 w_drop;

  // Space still allocatable: the guard band stays free so the scheduler can lag a pop
  assign w_free    = AW1'(RAM_WORDS) - r_committed - AW1'(r_wr_cnt) - AW1'(GUARD_WORDS);
  assign w_full    = (r_count == CW'(FIFO_WORDS));
  assign w_empty   = (r_count == '0);
  assign o_in_rdy  = r_live & ((r_state != IDLE) | ((w_free >= AW1'(MAX_LEN)) & ~w_full));
  assign w_accept  = i_in_vld & o_in_rdy;
  assign w_pop     = i_fifo_rden & ~w_empty;
  assign w_pop_len = r_desc[r_fifo_rp][RAM_DEPTH +: 10];

  assign o_fifo_dout = r_fifo_dout;
  assign o_pkt_rdy   = r_pkt_rdy;
  assign o_ram_dout  = r_ram_dout;
  assign o_drop_cnt  = r_drop_cnt;

  always_comb begin
    w_state_n  = r_state;
    w_wr_ptr_n = r_wr_ptr;
    w_start_n  = r_start;
    w_wr_cnt_n = r_wr_cnt;
    w_we       = 1'b0;
    w_waddr    = r_wr_ptr;
    w_push     = 1'b0;
    w_push_len = 10'd0;
    w_drop     = 1'b0;
    if (w_accept) begin
      if (i_in_sof) begin
        // A sof inside WRITE abandons the partial packet and reuses its start address
        w_drop     = (r_state == WRITE);
        w_waddr    = (r_state == WRITE) ? r_start : r_wr_ptr;
        w_we       = 1'b1;
        w_start_n  = w_waddr;
        w_wr_ptr_n = w_waddr + 1'b1;
        if (i_in_eof) begin
          w_push     = 1'b1;
          w_push_len = 10'd1;
          w_wr_cnt_n = 10'd0;
          w_state_n  = IDLE;
        end else begin
          w_wr_cnt_n = 10'd1;
          w_state_n  = WRITE;
        end
      end else begin
        case (r_state)
          IDLE: w_drop = 1'b1;
          WRITE: begin
            if (r_wr_cnt == 10'(MAX_LEN)) begin
              w_drop     = 1'b1;
              w_wr_ptr_n = r_start;
              w_wr_cnt_n = 10'd0;
              w_state_n  = i_in_eof ? IDLE : DROP;
            end else begin
              w_we       = 1'b1;
              w_wr_ptr_n = r_wr_ptr + 1'b1;
              if (i_in_eof) begin
                w_push     = 1'b1;
                w_push_len = r_wr_cnt + 10'd1;
                w_wr_cnt_n = 10'd0;
                w_state_n  = IDLE;
              end else begin
                w_wr_cnt_n = r_wr_cnt + 10'd1;
              end
            end
          end
          DROP: if (i_in_eof) w_state_n = IDLE;
          default: w_state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_start     <= '0;
      r_wr_cnt    <= '0;
      r_committed <= '0;
      r_count     <= '0;
      r_fifo_wp   <= '0;
      r_fifo_rp   <= '0;
      r_live      <= 1'b0;
      r_fifo_dout <= '0;
      r_pkt_rdy   <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_live      <= 1'b1;
      r_state     <= w_state_n;
      r_wr_ptr    <= w_wr_ptr_n;
      r_start     <= w_start_n;
      r_wr_cnt    <= w_wr_cnt_n;
      r_committed <= r_committed + AW1'(w_push_len) - (w_pop ? AW1'(w_pop_len) : AW1'(0));
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      r_pkt_rdy   <= (r_count != '0);
      if (w_push) r_fifo_wp <= r_fifo_wp + 1'b1;
      if (w_pop) begin
        r_fifo_rp   <= r_fifo_rp + 1'b1;
        r_fifo_dout <= r_desc[r_fifo_rp];
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_waddr] <= i_in_data;
    if (w_push) r_desc[r_fifo_wp] <= 24'({w_push_len, w_start_n});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ram_dout <= '0;
    else     r_ram_dout <= r_ram[i_ram_raddr];
  end

endmodule

// File: tb/tb_pkt_tx_buf.sv
// Directed bench for pkt_tx_buf: packet commit/pop, drops, space and FIFO limits, address wrap.
// The FIFO is widened to 32 entries so the RAM space limit can be reached without pops.
module tb_pkt_tx_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] inData = '0;
  logic        inSof = 1'b0, inEof = 1'b0, inVld = 1'b0;
  logic        inRdy;
  logic        fifoRden = 1'b0;
  logic [23:0] fifoDout;
  logic        pktRdy;
  logic [10:0] ramRaddr = '0;
  logic [15:0] ramDout;
  logic [15:0] dropCnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pkt_tx_buf #(.RAM_DEPTH(11), .DESC_AW(5), .MAX_LEN(94), .GUARD_WORDS(16)) dut (
    .clk(clk), .rst(rst),
    .i_in_data(inData), .i_in_sof(inSof), .i_in_eof(inEof), .i_in_vld(inVld),
    .o_in_rdy(inRdy), .i_fifo_rden(fifoRden), .o_fifo_dout(fifoDout),
    .o_pkt_rdy(pktRdy), .i_ram_raddr(ramRaddr), .o_ram_dout(ramDout),
    .o_drop_cnt(dropCnt)
  );

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_word(input logic [15:0] d, input logic sof, input logic eof);
    inData = d; inSof = sof; inEof = eof; inVld = 1'b1;
    @(posedge clk); #1;
    inVld = 1'b0; inSof = 1'b0; inEof = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) drive_word(base + 16'(i), i == 0, i == n - 1);
  endtask

  task automatic pop_desc();
    fifoRden = 1'b1;
    @(posedge clk); #1;
    fifoRden = 1'b0;
  endtask

  task automatic read_ram(input logic [10:0] a);
    ramRaddr = a;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inVld = 1'b0; inSof = 1'b0; inEof = 1'b0; fifoRden = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (inRdy !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_rdy got %b want 0", inRdy); end
    checks++; if (fifoDout !== 24'h0) begin errors++; $display("[TB] FAIL rst_fifo_dout got %h want 000000", fifoDout); end
    checks++; if (pktRdy !== 1'b0) begin errors++; $display("[TB] FAIL rst_pkt_rdy got %b want 0", pktRdy); end
    checks++; if (ramDout !== 16'h0) begin errors++; $display("[TB] FAIL rst_ram_dout got %h want 0000", ramDout); end
    checks++; if (dropCnt !== 16'h0) begin errors++; $display("[TB] FAIL rst_drop_cnt got %h want 0000", dropCnt); end
    rst = 1'b0;
    idle(1);
    checks++; if (inRdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_in_rdy got %b want 1", inRdy); end
  endtask

  task automatic test_basic();
    logic [15:0] exp [4];
    exp[0] = 16'hA00A; exp[1] = 16'hB00B; exp[2] = 16'hC00C; exp[3] = 16'hD00D;
    for (int i = 0; i < 4; i++) drive_word(exp[i], i == 0, i == 3);
    checks++; if (pktRdy !== 1'b0) begin errors++; $display("[TB] FAIL basic_pkt_rdy_eof1 got %b want 0", pktRdy); end
    idle(1);
    checks++; if (pktRdy !== 1'b1) begin errors++; $display("[TB] FAIL basic_pkt_rdy_eof2 got %b want 1", pktRdy); end
    pop_desc();
    checks++; if (fifoDout !== 24'h002000) begin errors++; $display("[TB] FAIL basic_desc got %h want 002000", fifoDout); end
    idle(1);
    checks++; if (pktRdy !== 1'b0) begin errors++; $display("[TB] FAIL basic_pkt_rdy_fall got %b want 0", pktRdy); end
    for (int i = 0; i < 4; i++) begin
      read_ram(11'(i));
      checks++; if (ramDout !== exp[i]) begin errors++; $display("[TB] FAIL basic_ram%0d got %h want %h", i, ramDout, exp[i]); end
    end
  endtask

  task automatic test_single_and_midsof();
    drive_word(16'h1111, 1'b1, 1'b1);
    idle(1);
    pop_desc();
    checks++; if (fifoDout !== 24'h000804) begin errors++; $display("[TB] FAIL single_desc got %h want 000804", fifoDout); end
    drive_word(16'h2221, 1'b1, 1'b0);
    drive_word(16'h2222, 1'b0, 1'b0);
    drive_word(16'h2223, 1'b1, 1'b0);
    drive_word(16'h2224, 1'b0, 1'b1);
    checks++; if (dropCnt !== 16'd1) begin errors++; $display("[TB] FAIL midsof_drop_cnt got %0d want 1", dropCnt); end
    idle(1);
    pop_desc();
    checks++; if (fifoDout !== 24'h001005) begin errors++; $display("[TB] FAIL midsof_desc got %h want 001005", fifoDout); end
    read_ram(11'd5);
    checks++; if (ramDout !== 16'h2223) begin errors++; $display("[TB] FAIL midsof_ram5 got %h want 2223", ramDout); end
    read_ram(11'd6);
    checks++; if (ramDout !== 16'h2224) begin errors++; $display("[TB] FAIL midsof_ram6 got %h want 2224", ramDout); end
  endtask

  task automatic test_oversize();
    send_pkt(95, 16'h7000);
    checks++; if (dropCnt !== 16'd2) begin errors++; $display("[TB] FAIL over_drop_cnt got %0d want 2", dropCnt); end
    idle(2);
    checks++; if (pktRdy !== 1'b0) begin errors++; $display("[TB] FAIL over_no_desc got %b want 0", pktRdy); end
    send_pkt(3, 16'h3000);
    idle(1);
    pop_desc();
    checks++; if (fifoDout !== 24'h001807) begin errors++; $display("[TB] FAIL over_next_desc got %h want 001807", fifoDout); end
    read_ram(11'd7);
    checks++; if (ramDout !== 16'h3000) begin errors++; $display("[TB] FAIL over_ram7 got %h want 3000", ramDout); end
    drive_word(16'hDEAD, 1'b0, 1'b0);
    checks++; if (dropCnt !== 16'd3) begin errors++; $display("[TB] FAIL stray_drop_cnt got %0d want 3", dropCnt); end
    send_pkt(94, 16'h4000);
    idle(1);
    pop_desc();
    checks++; if (fifoDout !== 24'h02F00A) begin errors++; $display("[TB] FAIL maxlen_desc got %h want 02F00A", fifoDout); end
    checks++; if (dropCnt !== 16'd3) begin errors++; $display("[TB] FAIL maxlen_drop_cnt got %0d want 3", dropCnt); end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 32; i++) drive_word(16'h0100 + 16'(i), 1'b1, 1'b1);
    checks++; if (inRdy !== 1'b0) begin errors++; $display("[TB] FAIL full_in_rdy got %b want 0", inRdy); end
    pop_desc();
    checks++; if (fifoDout !== 24'h000800) begin errors++; $display("[TB] FAIL full_first_desc got %h want 000800", fifoDout); end
    checks++; if (inRdy !== 1'b1) begin errors++; $display("[TB] FAIL full_after_pop_in_rdy got %b want 1", inRdy); end
    fifoRden = 1'b1;
    drive_word(16'h0120, 1'b1, 1'b1);
    fifoRden = 1'b0;
    checks++; if (fifoDout !== 24'h000801) begin errors++; $display("[TB] FAIL pushpop_desc got %h want 000801", fifoDout); end
    checks++; if (inRdy !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_in_rdy got %b want 1", inRdy); end
    drive_word(16'h0121, 1'b1, 1'b1);
    checks++; if (inRdy !== 1'b0) begin errors++; $display("[TB] FAIL refill_in_rdy got %b want 0", inRdy); end
    for (int i = 0; i < 32; i++) begin
      pop_desc();
      checks++;
      if (fifoDout !== 24'h000802 + 24'(i)) begin
        errors++; $display("[TB] FAIL drain_desc%0d got %h want %h", i, fifoDout, 24'h000802 + 24'(i));
      end
    end
    idle(1);
    checks++; if (pktRdy !== 1'b0) begin errors++; $display("[TB] FAIL drain_pkt_rdy got %b want 0", pktRdy); end
    pop_desc();
    checks++; if (fifoDout !== 24'h000821) begin errors++; $display("[TB] FAIL empty_pop got %h want 000821", fifoDout); end
  endtask

  task automatic test_space();
    for (int p = 0; p < 21; p++) begin
      checks++; if (inRdy !== 1'b1) begin errors++; $display("[TB] FAIL space_rdy_pkt%0d got %b want 1", p, inRdy); end
      send_pkt(94, 16'h8000);
    end
    checks++; if (inRdy !== 1'b0) begin errors++; $display("[TB] FAIL space_full_in_rdy got %b want 0", inRdy); end
    pop_desc();
    checks++; if (inRdy !== 1'b1) begin errors++; $display("[TB] FAIL space_pop_in_rdy got %b want 1", inRdy); end
    checks++; if (fifoDout !== 24'h02F000) begin errors++; $display("[TB] FAIL space_first_desc got %h want 02F000", fifoDout); end
    repeat (20) pop_desc();
    checks++; if (fifoDout !== 24'h02F758) begin errors++; $display("[TB] FAIL space_last_desc got %h want 02F758", fifoDout); end
  endtask

  task automatic test_wrap();
    send_pkt(66, 16'h9000);
    idle(1);
    pop_desc();
    checks++; if (fifoDout !== 24'h0217B6) begin errors++; $display("[TB] FAIL wrap_pre_desc got %h want 0217B6", fifoDout); end
    send_pkt(20, 16'h6000);
    idle(1);
    pop_desc();
    checks++; if (fifoDout !== 24'h00A7F8) begin errors++; $display("[TB] FAIL wrap_desc got %h want 00A7F8", fifoDout); end
    read_ram(11'd2040);
    checks++; if (ramDout !== 16'h6000) begin errors++; $display("[TB] FAIL wrap_ram2040 got %h want 6000", ramDout); end
    read_ram(11'd2047);
    checks++; if (ramDout !== 16'h6007) begin errors++; $display("[TB] FAIL wrap_ram2047 got %h want 6007", ramDout); end
    read_ram(11'd0);
    checks++; if (ramDout !== 16'h6008) begin errors++; $display("[TB] FAIL wrap_ram0 got %h want 6008", ramDout); end
    read_ram(11'd11);
    checks++; if (ramDout !== 16'h6013) begin errors++; $display("[TB] FAIL wrap_ram11 got %h want 6013", ramDout); end
    drive_word(16'hBAD0, 1'b0, 1'b0);
    drive_word(16'h5151, 1'b1, 1'b1);
    drive_word(16'h5200, 1'b1, 1'b0);
    drive_word(16'h5201, 1'b0, 1'b0);
    read_ram(11'd12);
    checks++; if (ramDout !== 16'h5151 || pktRdy !== 1'b1 || dropCnt !== 16'd1) begin
      errors++; $display("[TB] FAIL prerst_state got ram %h rdy %b drop %0d want 5151 1 1", ramDout, pktRdy, dropCnt);
    end
    rst = 1'b1;
    #1;
    checks++; if (inRdy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_rdy got %b want 0", inRdy); end
    checks++; if (fifoDout !== 24'h0) begin errors++; $display("[TB] FAIL midrst_fifo_dout got %h want 000000", fifoDout); end
    checks++; if (pktRdy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pkt_rdy got %b want 0", pktRdy); end
    checks++; if (ramDout !== 16'h0) begin errors++; $display("[TB] FAIL midrst_ram_dout got %h want 0000", ramDout); end
    checks++; if (dropCnt !== 16'h0) begin errors++; $display("[TB] FAIL midrst_drop_cnt got %h want 0000", dropCnt); end
    idle(1);
    rst = 1'b0;
    idle(1);
    drive_word(16'h5555, 1'b1, 1'b1);
    idle(1);
    pop_desc();
    checks++; if (fifoDout !== 24'h000800) begin errors++; $display("[TB] FAIL postrst_desc got %h want 000800", fifoDout); end
    read_ram(11'd0);
    checks++; if (ramDout !== 16'h5555) begin errors++; $display("[TB] FAIL postrst_ram0 got %h want 5555", ramDout); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_single_and_midsof();
    test_oversize();
    test_reset();
    test_fifo_full();
    test_reset();
    test_space();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
